// File: rtl/serial_add_ctrl_pkg.sv
// Shared types and sizing helpers for the slice-sequenced add/subtract controller.
package serial_add_ctrl_pkg;

    // Width of the one adder slice that exists in this codebase.
    localparam int SLICE_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int n_slices(input int width, input int slice);
        return width / slice;
    endfunction

    // A one-slice configuration still needs a 1-bit index register.
    function automatic int idx_width(input int nslice);
        return (nslice > 1) ? $clog2(nslice) : 1;
    endfunction

endpackage

// File: rtl/serial_add_ctrl_slice.sv
// 8-bit ripple-carry adder slice; the only arithmetic in the controller.
module serial_add_ctrl_slice
    import serial_add_ctrl_pkg::*;
(
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               cin,
    output logic [SLICE_W-1:0] s,
    output logic               cout
);

    logic [SLICE_W:0] c;

    // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned and infers a latch.
    always_comb begin
        c    = '0;
        s    = '0;
        c[0] = cin;
        for (int i = 0; i < SLICE_W; i++) begin
            s[i]     = a[i] ^ b[i] ^ c[i];
            c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
        cout = c[SLICE_W];
    end

endmodule

// File: rtl/serial_add_ctrl.sv
// Multi-cycle add/subtract: one shared slice walks the operands LSB slice first,
// chaining the carry through a register, with a start/busy/done handshake.
module serial_add_ctrl
    import serial_add_ctrl_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             overflow
);

    localparam int NSLICE = n_slices(WIDTH, SLICE);
    localparam int IW     = idx_width(NSLICE);
    localparam logic [IW-1:0] LAST_IDX = IW'(NSLICE - 1);

    state_t           state;
    logic [IW-1:0]    idx;
    logic             carry;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;

    logic [SLICE-1:0] a_sl;
    logic [SLICE-1:0] b_sl;
    logic [SLICE-1:0] s_sl;
    logic             sl_cout;
    logic             accept;

    // Requests are only taken while ready; a start during RUN leaves no trace.
    assign accept = start && ((state == IDLE) || (state == DONE));

    always_comb begin
        a_sl = '0;
        b_sl = '0;
        for (int k = 0; k < NSLICE; k++) begin
            if (idx == IW'(k)) begin
                a_sl = a_reg[k*SLICE +: SLICE];
                b_sl = b_reg[k*SLICE +: SLICE];
            end
        end
    end

    serial_add_ctrl_slice u_slice (
        .a    (a_sl),
        .b    (b_sl),
        .cin  (carry),
        .s    (s_sl),
        .cout (sl_cout)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            idx      <= '0;
            carry    <= 1'b0;
            a_reg    <= '0;
            b_reg    <= '0;
            sum      <= '0;
            c_out    <= 1'b0;
            overflow <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else if (accept) begin
            // Subtraction is a + ~b + 1: invert B here and seed the carry with sub.
            a_reg <= a;
            b_reg <= b ^ {WIDTH{sub}};
            carry <= sub;
            idx   <= '0;
            state <= RUN;
            busy  <= 1'b1;
            done  <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    for (int k = 0; k < NSLICE; k++) begin
                        if (idx == IW'(k)) begin
                            sum[k*SLICE +: SLICE] <= s_sl;
                        end
                    end
                    carry <= sl_cout;
                    if (idx == LAST_IDX) begin
                        // Carry into the MSB is recovered from the MSB sum bit and its operands.
                        c_out    <= sl_cout;
                        overflow <= sl_cout ^ (a_reg[WIDTH-1] ^ b_reg[WIDTH-1] ^ s_sl[SLICE-1]);
                        idx      <= '0;
                        state    <= DONE;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
                IDLE: begin
                    done <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl at WIDTH=32, SLICE=8.
module tb_serial_add_ctrl;

    localparam int WIDTH   = 32;
    localparam int LATENCY = 5;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             c_out;
    logic             overflow;

    typedef struct {
        logic [WIDTH-1:0] sum;
        logic             c;
        logic             v;
        int               issue;
    } exp_t;

    exp_t q[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;

    serial_add_ctrl #(.WIDTH(WIDTH), .SLICE(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .sub      (sub),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .sum      (sum),
        .c_out    (c_out),
        .overflow (overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference arithmetic done at full width with an explicit 33-bit sum.
    function automatic exp_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                   input logic s, input int issue);
        exp_t e;
        logic [WIDTH-1:0] yy;
        logic [WIDTH:0]   full;
        yy      = s ? ~y : y;
        full    = {1'b0, x} + {1'b0, yy} + {{WIDTH{1'b0}}, s};
        e.sum   = full[WIDTH-1:0];
        e.c     = full[WIDTH];
        e.v     = (x[WIDTH-1] == yy[WIDTH-1]) && (e.sum[WIDTH-1] != x[WIDTH-1]);
        e.issue = issue;
        return e;
    endfunction

    always @(negedge clk) begin
        if (!rst && done) begin
            if (q.size() == 0) begin
                check("spurious_done", 1, 0);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("sum", sum, e.sum);
                check("c_out", c_out, e.c);
                check("overflow", overflow, e.v);
                check("latency", cyc - e.issue, LATENCY);
            end
        end
    end

    task automatic drive(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                         input logic s, input bit expect_accept);
        start = 1'b1;
        a     = x;
        b     = y;
        sub   = s;
        if (expect_accept) q.push_back(model(x, y, s, cyc));
    endtask

    task automatic scramble();
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
        sub   = 1'($urandom_range(0, 1));
    endtask

    // Leaves the caller on the negedge where done is high.
    task automatic wait_done(output int busy_cnt);
        int n;
        busy_cnt = 0;
        n = 0;
        while (!done && n < 20) begin
            if (busy) busy_cnt++;
            @(negedge clk);
            n++;
        end
        if (!done) check("done_timeout", 0, 1);
    endtask

    task automatic run_op(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                          input logic s, output int busy_cnt);
        @(negedge clk);
        drive(x, y, s, 1'b1);
        @(negedge clk);
        scramble();
        wait_done(busy_cnt);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "bench did not finish");
    end

    initial begin
        int bc;
        int dcnt;
        rst   = 1'b1;
        start = 1'b0;
        sub   = 1'b0;
        a     = '0;
        b     = '0;
        repeat (3) @(negedge clk);
        check("rst_sum", sum, 0);
        check("rst_c_out", c_out, 0);
        check("rst_overflow", overflow, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        rst = 1'b0;
        @(negedge clk);

        // Carry out of the top, and done lasts one cycle.
        run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, bc);
        @(negedge clk);
        check("done_pulse_width", done, 0);

        run_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, bc);
        check("busy_cycles", bc, 4);

        run_op(32'h0000_0005, 32'h0000_0007, 1'b1, bc);
        run_op(32'h8000_0000, 32'h0000_0001, 1'b1, bc);

        // Reset in the third RUN cycle: everything clears without a clock edge.
        @(negedge clk);
        drive(32'h0F0F_0F0F, 32'h1234_5678, 1'b0, 1'b0);
        @(negedge clk);
        scramble();
        @(negedge clk);
        @(negedge clk);
        check("pre_rst_busy", busy, 1);
        #1 rst = 1'b1;
        #1;
        check("async_rst_sum", sum, 0);
        check("async_rst_c_out", c_out, 0);
        check("async_rst_overflow", overflow, 0);
        check("async_rst_busy", busy, 0);
        check("async_rst_done", done, 0);
        @(negedge clk);
        rst = 1'b0;
        dcnt = 0;
        repeat (8) begin
            @(negedge clk);
            if (done) dcnt++;
        end
        check("no_done_after_rst", dcnt, 0);
        run_op(32'hDEAD_BEEF, 32'h0123_4567, 1'b0, bc);

        // Start during RUN is ignored.
        @(negedge clk);
        drive(32'h0000_0010, 32'h0000_0020, 1'b0, 1'b1);
        @(negedge clk);
        scramble();
        @(negedge clk);
        drive(32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0);
        @(negedge clk);
        scramble();
        wait_done(bc);
        dcnt = 0;
        repeat (8) begin
            @(negedge clk);
            if (done) dcnt++;
        end
        check("single_done", dcnt, 0);

        // Start held in the done cycle is accepted back-to-back.
        @(negedge clk);
        drive(32'h0000_0001, 32'h0000_0002, 1'b0, 1'b1);
        @(negedge clk);
        scramble();
        wait_done(bc);
        drive(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b1);
        @(negedge clk);
        scramble();
        check("b2b_busy", busy, 1);
        wait_done(bc);

        // Subtract with borrow chained across every slice boundary.
        run_op(32'h0000_0000, 32'h0000_0001, 1'b1, bc);

        repeat (3) @(negedge clk);
        check("sb_empty", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
